dma_priority_resolver: RTL and testbench
========================================

Name: dma_priority_resolver

Overview:
- Priority resolver stage of the 8237A-style DMA controller, directly upstream of the timing-and-control block.
- Conditions the four raw DREQ inputs with polarity, mask and enable, then arbitrates with fixed or rotating priority.
- Drives a one-hot VALID_DREQ0..3 winner to timing-and-control.
- Completes the request/acknowledge handshake using hrq and validDACK from timing-and-control, and drives the external DACK pins.

Parameters:
- NUM_CH, 4, number of DMA channels; the design is fixed at 4 and NUM_CH is a documentation constant only.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RESET  input  1  synchronous, active-low reset
- DREQ  input  4  raw channel requests, polarity set by cmdDreqSenseLow
- maskReg  input  4  per-channel mask; 1 = channel masked
- cmdCtrlDisable  input  1  command bit 2; 1 = controller disabled, no new arbitration
- cmdRotPrio  input  1  command bit 4; 1 = rotating priority, 0 = fixed (ch0 highest)
- cmdDreqSenseLow  input  1  command bit 6; 1 = DREQ active low
- cmdDackSenseHigh  input  1  command bit 7; 1 = DACK active high
- hrq  input  1  hold request from timing-and-control; falling edge marks end of service
- validDACK  input  1  timing-and-control has received HLDA and is ready to acknowledge
- VALID_DREQ0..3  output  1 each  one-hot granted request to timing-and-control
- DACK  output  4  external acknowledges, polarity per cmdDackSenseHigh
- activeCh  output  2  encoded index of the current winner (debug/datapath select)

Behaviour:
- Reset (RESET==0 at a clock edge):
  - state=IDLE; VALID_DREQ0..3=0; activeCh=0; prioPtr=0.
  - DACK driven inactive. Reset values assume the DACK sense bit low (active-low); DACK tracks the sense bit combinationally.
- Effective request: effReq[n] = (DREQ[n] ^ cmdDreqSenseLow) & ~maskReg[n].
- IDLE:
  - Stay in IDLE if cmdCtrlDisable==1 or effReq==0.
  - Otherwise pick the winner: the first set bit scanning from prioPtr upward, modulo 4.
  - Register the one-hot VALID_DREQn and activeCh; go to PENDING. Latency: 1 clock from effReq seen to VALID_DREQn high.
- PENDING:
  - Winner is frozen; a higher-priority request arriving now does not preempt.
  - If effReq[winner] drops (deasserted or masked) before validDACK: clear VALID_DREQ on the next edge and return to IDLE.
  - If validDACK==1: go to GRANTED and assert DACK[winner] on the next edge.
  - If both happen in the same cycle, validDACK wins.
- GRANTED:
  - VALID_DREQn and DACK[winner] are held regardless of DREQ changes.
  - When hrq==0 is sampled: drop DACK and VALID_DREQ on the next edge; go to IDLE.
  - On that same edge, if cmdRotPrio==1, prioPtr = winner+1 mod 4; if cmdRotPrio==0, prioPtr = 0.
  - Re-arbitration takes at least one cycle in IDLE; no back-to-back grant on the same edge.
- cmdRotPrio changing mid-service affects only the next pointer update.
- cmdCtrlDisable set while PENDING or GRANTED does not abort service.
- Only one of VALID_DREQ0..3 may be high at any time; the same holds for active DACK bits.

Optional Feature:
- Macro: DMA_PR_SWREQ_EN.
- When defined:
  - Adds input swReq[3:0] (software request register).
  - effReq[n] |= swReq[n]. Software requests ignore maskReg and DREQ polarity.
  - Withdrawal in PENDING considers the combined request.
- When undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package dma_pkg:
  - typedef enum {IDLE, PENDING, GRANTED} pr_state_t
  - NUM_CH=4
  - command-bit index constants CMD_DISABLE=2, CMD_ROTPRIO=4, CMD_DREQ_LOW=6, CMD_DACK_HIGH=7
- Sub-module dma_prio_arbiter: purely combinational rotating one-hot picker with inputs (req[3:0], ptr[1:0]) and outputs (grant[3:0], idx[1:0], any).

Test Plan:
- Fixed priority, DREQ=4'b1010 active-high, mask=0 -> VALID_DREQ1=1 one clock later; validDACK=1 -> DACK[1] asserted next clock; hrq falls -> all outputs clear, prioPtr stays 0.
- Rotating priority, ch1 serviced, then DREQ=4'b0011 -> prioPtr=2, ch0 wins (scan 2,3,0); after ch0 service prioPtr=1.
- maskReg=4'b0001, DREQ=4'b0001 -> VALID_DREQ stays 0; unmask -> VALID_DREQ0 one clock later.
- PENDING with DREQ2 withdrawn before validDACK -> VALID_DREQ2 clears next edge and the block returns to IDLE; same-cycle withdrawal with validDACK=1 -> DACK[2] asserted.
- cmdDreqSenseLow=1, cmdDackSenseHigh=0, DREQ=4'b1110 -> ch0 wins; DACK=4'b1110 during GRANTED.
- RESET low during GRANTED -> next edge: VALID all 0, DACK inactive, state IDLE, prioPtr=0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA priority resolver.
package dma_pkg;

  // Channel count; the resolver is built for exactly four channels.
  localparam int unsigned NUM_CH = 4;

  // Command register bit positions feeding the resolver.
  localparam int unsigned CMD_DISABLE   = 2;
  localparam int unsigned CMD_ROTPRIO   = 4;
  localparam int unsigned CMD_DREQ_LOW  = 6;
  localparam int unsigned CMD_DACK_HIGH = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    GRANTED = 2'd2
  } pr_state_t;

endpackage

// File: rtl/dma_priority_resolver_if.sv
// Request/acknowledge bundle between channel logic, the priority resolver and
// timing-and-control. The optional swReq input exists only with DMA_PR_SWREQ_EN.
interface dma_priority_resolver_if;
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic       cmdCtrlDisable;
  logic       cmdRotPrio;
  logic       cmdDreqSenseLow;
  logic       cmdDackSenseHigh;
  logic       hrq;
  logic       validDACK;
`ifdef DMA_PR_SWREQ_EN
  logic [3:0] swReq;
`endif
  logic       VALID_DREQ0;
  logic       VALID_DREQ1;
  logic       VALID_DREQ2;
  logic       VALID_DREQ3;
  logic [3:0] DACK;
  logic [1:0] activeCh;

`ifdef DMA_PR_SWREQ_EN
  modport slave (
    input  DREQ, maskReg, cmdCtrlDisable, cmdRotPrio, cmdDreqSenseLow, cmdDackSenseHigh,
    input  hrq, validDACK, swReq,
    output VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3, DACK, activeCh
  );
  modport master (
    output DREQ, maskReg, cmdCtrlDisable, cmdRotPrio, cmdDreqSenseLow, cmdDackSenseHigh,
    output hrq, validDACK, swReq,
    input  VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3, DACK, activeCh
  );
`else
  modport slave (
    input  DREQ, maskReg, cmdCtrlDisable, cmdRotPrio, cmdDreqSenseLow, cmdDackSenseHigh,
    input  hrq, validDACK,
    output VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3, DACK, activeCh
  );
  modport master (
    output DREQ, maskReg, cmdCtrlDisable, cmdRotPrio, cmdDreqSenseLow, cmdDackSenseHigh,
    output hrq, validDACK,
    input  VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3, DACK, activeCh
  );
`endif

endinterface

// File: rtl/dma_prio_arbiter.sv
// Combinational rotating one-hot picker: first set request scanning upward from ptr.
module dma_prio_arbiter
  import dma_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  // Scan ptr, ptr+1, ... with 2-bit wraparound; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = ptr + 2'(i);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_resolver.sv
// DMA priority resolver: conditions DREQ with polarity/mask, arbitrates fixed or
// rotating, and runs the request/acknowledge handshake with timing-and-control.
// Optional software requests are enabled by defining DMA_PR_SWREQ_EN.
module dma_priority_resolver
  import dma_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RESET,
  dma_priority_resolver_if.slave  bus
);

  pr_state_t  state_q;
  logic [3:0] valid_q;
  logic [3:0] dack_q;    // active-high internally, polarity applied at the pin
  logic [1:0] ch_q;
  logic [1:0] prio_ptr_q;

  logic [3:0] eff_req;
  logic [3:0] arb_grant;
  logic [1:0] arb_idx;
  logic       arb_any;

  // Effective requests after sense polarity and mask (plus software requests).
  always_comb begin
    eff_req = (bus.DREQ ^ {4{bus.cmdDreqSenseLow}}) & ~bus.maskReg;
`ifdef DMA_PR_SWREQ_EN
    eff_req = eff_req | bus.swReq;
`endif
  end

  dma_prio_arbiter u_arbiter (
    .req   (eff_req),
    .ptr   (prio_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Handshake FSM with registered grant, acknowledge and pointer.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dack_q     <= '0;
      ch_q       <= '0;
      prio_ptr_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!bus.cmdCtrlDisable && arb_any) begin
            valid_q <= arb_grant;
            ch_q    <= arb_idx;
            state_q <= PENDING;
          end
        end
        PENDING: begin
          // validDACK takes precedence over a same-cycle withdrawal.
          if (bus.validDACK) begin
            dack_q  <= valid_q;
            state_q <= GRANTED;
          end else if (!eff_req[ch_q]) begin
            valid_q <= '0;
            state_q <= IDLE;
          end
        end
        GRANTED: begin
          if (!bus.hrq) begin
            valid_q    <= '0;
            dack_q     <= '0;
            state_q    <= IDLE;
            prio_ptr_q <= bus.cmdRotPrio ? ch_q + 2'd1 : 2'd0;
          end
        end
        default: begin
          valid_q <= '0;
          dack_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output drive; DACK polarity follows the sense bit combinationally.
  always_comb begin
    bus.VALID_DREQ0 = valid_q[0];
    bus.VALID_DREQ1 = valid_q[1];
    bus.VALID_DREQ2 = valid_q[2];
    bus.VALID_DREQ3 = valid_q[3];
    bus.DACK        = bus.cmdDackSenseHigh ? dack_q : ~dack_q;
    bus.activeCh    = ch_q;
  end

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed bench for dma_priority_resolver with a queue-based expectation scoreboard.
module tb_dma_priority_resolver;
  import dma_pkg::*;

  typedef struct {
    string      tag;
    logic [3:0] valid;
    logic [3:0] dack;
    logic [1:0] ch;
    logic [1:0] ptr;
    pr_state_t  st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  dma_priority_resolver_if bus ();

  dma_priority_resolver dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Queue the expected post-edge outputs, clock once, then compare.
  task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] d,
                     input logic [1:0] c, input logic [1:0] p, input pr_state_t s);
    exp_t e;
    e.tag = tag; e.valid = v; e.dack = d; e.ch = c; e.ptr = p; e.st = s;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "/valid"}, {bus.VALID_DREQ3, bus.VALID_DREQ2, bus.VALID_DREQ1, bus.VALID_DREQ0},
        e.valid);
    chk({e.tag, "/dack"}, bus.DACK, e.dack);
    chk({e.tag, "/ch"}, {2'b00, bus.activeCh}, {2'b00, e.ch});
    chk({e.tag, "/ptr"}, {2'b00, dut.prio_ptr_q}, {2'b00, e.ptr});
    chk({e.tag, "/state"}, {2'b00, dut.state_q}, {2'b00, e.st});
  endtask

  initial begin
    rst_n = 1'b0;
    bus.DREQ = 4'b0000; bus.maskReg = 4'b0000;
    bus.cmdCtrlDisable = 1'b0; bus.cmdRotPrio = 1'b0;
    bus.cmdDreqSenseLow = 1'b0; bus.cmdDackSenseHigh = 1'b0;
    bus.hrq = 1'b1; bus.validDACK = 1'b0;
`ifdef DMA_PR_SWREQ_EN
    bus.swReq = 4'b0000;
`endif
    cyc("reset", 4'b0000, 4'b1111, 2'd0, 2'd0, IDLE);
    rst_n = 1'b1;

    // Fixed priority: ch1 wins over ch3.
    bus.DREQ = 4'b1010;
    cyc("fix_pend", 4'b0010, 4'b1111, 2'd1, 2'd0, PENDING);
    cyc("fix_hold", 4'b0010, 4'b1111, 2'd1, 2'd0, PENDING);
    bus.validDACK = 1'b1;
    cyc("fix_grant", 4'b0010, 4'b1101, 2'd1, 2'd0, GRANTED);
    bus.validDACK = 1'b0; bus.DREQ = 4'b0000;
    cyc("fix_keep", 4'b0010, 4'b1101, 2'd1, 2'd0, GRANTED);
    bus.hrq = 1'b0;
    cyc("fix_end", 4'b0000, 4'b1111, 2'd1, 2'd0, IDLE);
    bus.hrq = 1'b1;

    // Rotating priority: ch1 then ptr=2, ch0 wins from {0,1}, then ptr=1.
    bus.cmdRotPrio = 1'b1; bus.DREQ = 4'b0010;
    cyc("rot1_pend", 4'b0010, 4'b1111, 2'd1, 2'd0, PENDING);
    bus.validDACK = 1'b1;
    cyc("rot1_grant", 4'b0010, 4'b1101, 2'd1, 2'd0, GRANTED);
    bus.validDACK = 1'b0; bus.hrq = 1'b0; bus.DREQ = 4'b0000;
    cyc("rot1_end", 4'b0000, 4'b1111, 2'd1, 2'd2, IDLE);
    bus.hrq = 1'b1; bus.DREQ = 4'b0011;
    cyc("rot2_pend", 4'b0001, 4'b1111, 2'd0, 2'd2, PENDING);
    bus.validDACK = 1'b1;
    cyc("rot2_grant", 4'b0001, 4'b1110, 2'd0, 2'd2, GRANTED);
    bus.validDACK = 1'b0; bus.hrq = 1'b0; bus.DREQ = 4'b0000;
    cyc("rot2_end", 4'b0000, 4'b1111, 2'd0, 2'd1, IDLE);
    bus.hrq = 1'b1;

    // Back to fixed: pointer clears at end of this service.
    bus.cmdRotPrio = 1'b0; bus.DREQ = 4'b0001;
    cyc("fix2_pend", 4'b0001, 4'b1111, 2'd0, 2'd1, PENDING);
    bus.validDACK = 1'b1;
    cyc("fix2_grant", 4'b0001, 4'b1110, 2'd0, 2'd1, GRANTED);
    bus.validDACK = 1'b0; bus.hrq = 1'b0; bus.DREQ = 4'b0000;
    cyc("fix2_end", 4'b0000, 4'b1111, 2'd0, 2'd0, IDLE);
    bus.hrq = 1'b1;

    // No preemption in PENDING; withdrawal returns to IDLE.
    bus.DREQ = 4'b1000;
    cyc("pre_pend", 4'b1000, 4'b1111, 2'd3, 2'd0, PENDING);
    bus.DREQ = 4'b1001;
    cyc("pre_frozen", 4'b1000, 4'b1111, 2'd3, 2'd0, PENDING);
    bus.DREQ = 4'b0000;
    cyc("pre_wd", 4'b0000, 4'b1111, 2'd3, 2'd0, IDLE);

    // Mask blocks, unmask grants one clock later, masking withdraws.
    bus.maskReg = 4'b0001; bus.DREQ = 4'b0001;
    cyc("mask_block", 4'b0000, 4'b1111, 2'd3, 2'd0, IDLE);
    bus.maskReg = 4'b0000;
    cyc("mask_open", 4'b0001, 4'b1111, 2'd0, 2'd0, PENDING);
    bus.maskReg = 4'b0001;
    cyc("mask_wd", 4'b0000, 4'b1111, 2'd0, 2'd0, IDLE);
    bus.maskReg = 4'b0000; bus.DREQ = 4'b0000;

    // Withdrawal of ch2, then same-cycle withdrawal with validDACK.
    bus.DREQ = 4'b0100;
    cyc("wd_pend", 4'b0100, 4'b1111, 2'd2, 2'd0, PENDING);
    bus.DREQ = 4'b0000;
    cyc("wd_idle", 4'b0000, 4'b1111, 2'd2, 2'd0, IDLE);
    bus.DREQ = 4'b0100;
    cyc("race_pend", 4'b0100, 4'b1111, 2'd2, 2'd0, PENDING);
    bus.DREQ = 4'b0000; bus.validDACK = 1'b1;
    cyc("race_grant", 4'b0100, 4'b1011, 2'd2, 2'd0, GRANTED);
    bus.validDACK = 1'b0; bus.hrq = 1'b0;
    cyc("race_end", 4'b0000, 4'b1111, 2'd2, 2'd0, IDLE);
    bus.hrq = 1'b1;

    // Disable blocks arbitration but does not abort service in progress.
    bus.cmdCtrlDisable = 1'b1; bus.DREQ = 4'b0100;
    cyc("dis_block", 4'b0000, 4'b1111, 2'd2, 2'd0, IDLE);
    bus.cmdCtrlDisable = 1'b0;
    cyc("dis_pend", 4'b0100, 4'b1111, 2'd2, 2'd0, PENDING);
    bus.cmdCtrlDisable = 1'b1; bus.validDACK = 1'b1;
    cyc("dis_grant", 4'b0100, 4'b1011, 2'd2, 2'd0, GRANTED);
    bus.cmdCtrlDisable = 1'b0; bus.validDACK = 1'b0; bus.hrq = 1'b0; bus.DREQ = 4'b0000;
    cyc("dis_end", 4'b0000, 4'b1111, 2'd2, 2'd0, IDLE);
    bus.hrq = 1'b1;

    // Active-low DREQ: 1110 means only ch0 requests; DACK sense toggled live.
    bus.cmdRotPrio = 1'b1; bus.cmdDreqSenseLow = 1'b1; bus.DREQ = 4'b1110;
    cyc("low_pend", 4'b0001, 4'b1111, 2'd0, 2'd0, PENDING);
    bus.validDACK = 1'b1;
    cyc("low_grant", 4'b0001, 4'b1110, 2'd0, 2'd0, GRANTED);
    bus.validDACK = 1'b0; bus.cmdDackSenseHigh = 1'b1;
    cyc("dack_high", 4'b0001, 4'b0001, 2'd0, 2'd0, GRANTED);
    bus.cmdDackSenseHigh = 1'b0; bus.hrq = 1'b0;
    cyc("low_end", 4'b0000, 4'b1111, 2'd0, 2'd1, IDLE);
    bus.hrq = 1'b1;
    cyc("low_pend2", 4'b0001, 4'b1111, 2'd0, 2'd1, PENDING);
    bus.validDACK = 1'b1;
    cyc("low_grant2", 4'b0001, 4'b1110, 2'd0, 2'd1, GRANTED);

    // Reset while GRANTED.
    rst_n = 1'b0; bus.validDACK = 1'b0;
    cyc("rst_grant", 4'b0000, 4'b1111, 2'd0, 2'd0, IDLE);
    rst_n = 1'b1; bus.cmdDreqSenseLow = 1'b0; bus.cmdRotPrio = 1'b0; bus.DREQ = 4'b0000;
    cyc("post_rst", 4'b0000, 4'b1111, 2'd0, 2'd0, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
